divisor_frecuencia_multi: RTL and testbench

Parametrised multi-channel frequency divider for the digital-clock design. It generates NCH independent divided outputs from one system clock, each with a square wave and a one-cycle tick, for the seconds, minutes, hours, display-scan and blink time bases. Divisors are runtime-programmable through a write port and use glitch-free shadow loading. Channels have individual enables and a common phase-align strobe.

---
 rtl/divisor_pkg.sv | 32 +++
 rtl/divisor_canal.sv | 86 ++++++++
 rtl/divisor_frecuencia_multi.sv | 47 ++++
 tb/tb_divisor_frecuencia_multi.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// Shared constants and types for the digital-clock frequency divider.
package divisor_pkg;

    // Default counter/divisor width and channel limit.
    localparam int WIDTH_DEFAULT = 38;
    localparam int NCH_MAX       = 16;

    // System clock feeding the clock design.
    localparam longint unsigned CLK_HZ = 50_000_000;

    // Divisor D giving a square wave of out_hz: the output period is 2(D+1) cycles.
    function automatic logic [WIDTH_DEFAULT-1:0] div_for_hz(
        input longint unsigned clk_hz,
        input longint unsigned out_hz
    );
        return WIDTH_DEFAULT'(clk_hz / (2 * out_hz) - 1);
    endfunction

    // Named time bases of the clock design.
    localparam logic [WIDTH_DEFAULT-1:0] DIV_1HZ   = div_for_hz(CLK_HZ, 1);     // seconds
    localparam logic [WIDTH_DEFAULT-1:0] DIV_SCAN  = div_for_hz(CLK_HZ, 1000);  // display scan
    localparam logic [WIDTH_DEFAULT-1:0] DIV_BLINK = div_for_hz(CLK_HZ, 2);     // blink
    localparam logic [WIDTH_DEFAULT-1:0] DIV_DEFAULT = DIV_1HZ;

    // What a channel does on a given edge.
    typedef enum logic [1:0] {
        MODO_PARADO = 2'd0,  // disabled or sync strobe: hold at phase zero
        MODO_CUENTA = 2'd1,  // counting inside the period
        MODO_WRAP   = 2'd2   // last cycle of the period
    } modo_e;

endpackage

// File: rtl/divisor_canal.sv
// One divider channel: counter, active/pending divisor, square and tick outputs.
module divisor_canal
    import divisor_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] DIV_DEFAULT = WIDTH'(divisor_pkg::DIV_DEFAULT)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             habilitar,
    input  logic             sincronizar,
    input  logic             wr_sel,
    input  logic [WIDTH-1:0] wr_dato,
    output logic             salida,
    output logic             tick
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] activo_q, activo_d;
    logic [WIDTH-1:0] pendiente_q, pendiente_d;
    logic             salida_q, salida_d;
    logic             tick_q, tick_d;
    modo_e            modo;

    // Classify this edge; sync overrides the enable, a wrap happens when count reaches the divisor.
    always_comb begin
        if (sincronizar || !habilitar) begin
            modo = MODO_PARADO;
        end else if (count_q == activo_q) begin
            modo = MODO_WRAP;
        end else begin
            modo = MODO_CUENTA;
        end
    end

    // Next-state logic; the pending divisor only reaches activo at a wrap or while stopped.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        count_d     = count_q;
        activo_d    = activo_q;
        salida_d    = salida_q;
        tick_d      = 1'b0;
        pendiente_d = wr_sel ? wr_dato : pendiente_q;
        unique case (modo)
            MODO_PARADO: begin
                count_d  = '0;
                salida_d = 1'b0;
                activo_d = pendiente_q;
            end
            MODO_WRAP: begin
                count_d  = '0;
                salida_d = ~salida_q;
                tick_d   = 1'b1;
                activo_d = pendiente_q;
            end
            MODO_CUENTA: begin
                count_d = count_q + WIDTH'(1);
            end
            default: begin
                count_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; a write in a reset cycle is dropped.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            count_q     <= '0;
            activo_q    <= DIV_DEFAULT;
            pendiente_q <= DIV_DEFAULT;
            salida_q    <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            activo_q    <= activo_d;
            pendiente_q <= pendiente_d;
            salida_q    <= salida_d;
            tick_q      <= tick_d;
        end
    end

    assign salida = salida_q;
    assign tick   = tick_q;

endmodule

// File: rtl/divisor_frecuencia_multi.sv
// Multi-channel programmable frequency divider: write decode plus NCH channel instances.
module divisor_frecuencia_multi
    import divisor_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEFAULT,
    parameter int               NCH         = 4,
    parameter int               CW          = (NCH > 1) ? $clog2(NCH) : 1,
    parameter logic [WIDTH-1:0] DIV_DEFAULT = WIDTH'(divisor_pkg::DIV_DEFAULT)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NCH-1:0]   habilitar,
    input  logic             sincronizar,
    input  logic             wr_en,
    input  logic [CW-1:0]    wr_canal,
    input  logic [WIDTH-1:0] wr_dato,
    output logic [NCH-1:0]   salida,
    output logic [NCH-1:0]   tick
);

    logic [NCH-1:0] wr_sel;

    // One-hot write strobe per channel; out-of-range channel numbers select nothing.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_sel[i] = wr_en && (wr_canal == CW'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_canal
        divisor_canal #(
            .WIDTH       (WIDTH),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_canal (
            .clock       (clock),
            .reset_n     (reset_n),
            .habilitar   (habilitar[g]),
            .sincronizar (sincronizar),
            .wr_sel      (wr_sel[g]),
            .wr_dato     (wr_dato),
            .salida      (salida[g]),
            .tick        (tick[g])
        );
    end

endmodule

// File: tb/tb_divisor_frecuencia_multi.sv
// Testbench for divisor_frecuencia_multi (WIDTH=8, NCH=3, DIV_DEFAULT=3).
module tb_divisor_frecuencia_multi;

    localparam int WIDTH = 8;
    localparam int NCH   = 3;
    localparam int CW    = 2;
    localparam int DEF   = 3;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [NCH-1:0]   habilitar;
    logic             sincronizar;
    logic             wr_en;
    logic [CW-1:0]    wr_canal;
    logic [WIDTH-1:0] wr_dato;
    logic [NCH-1:0]   salida;
    logic [NCH-1:0]   tick;

    int vec_count   = 0;
    int miscompares = 0;

    // Reference model: per channel, edges into current period, wraps since restart, divisors.
    int       m_k     [NCH];
    int       m_wraps [NCH];
    int       m_cur   [NCH];
    int       m_pend  [NCH];
    logic [NCH-1:0] m_tick = '0;

    divisor_frecuencia_multi #(
        .WIDTH       (WIDTH),
        .NCH         (NCH),
        .CW          (CW),
        .DIV_DEFAULT (8'(DEF))
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .habilitar   (habilitar),
        .sincronizar (sincronizar),
        .wr_en       (wr_en),
        .wr_canal    (wr_canal),
        .wr_dato     (wr_dato),
        .salida      (salida),
        .tick        (tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            int old_pend;
            if (!reset_n) begin
                m_cur[i]   = DEF;
                m_pend[i]  = DEF;
                m_k[i]     = 0;
                m_wraps[i] = 0;
                m_tick[i]  = 1'b0;
            end else begin
                old_pend = m_pend[i];
                if (wr_en && int'(wr_canal) == i) m_pend[i] = int'(wr_dato);
                if (sincronizar || !habilitar[i]) begin
                    m_k[i]     = 0;
                    m_wraps[i] = 0;
                    m_cur[i]   = old_pend;
                    m_tick[i]  = 1'b0;
                end else begin
                    m_k[i]++;
                    if (m_k[i] == m_cur[i] + 1) begin
                        m_k[i] = 0;
                        m_wraps[i]++;
                        m_tick[i] = 1'b1;
                        m_cur[i]  = old_pend;
                    end else begin
                        m_tick[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    // One clock edge: update model, sample outputs 1 ns later, compare against the model.
    task automatic step();
        logic [NCH-1:0] exp_s;
        @(posedge clock);
        model_edge();
        #1;
        for (int i = 0; i < NCH; i++) exp_s[i] = (m_wraps[i] % 2) != 0;
        check("model_salida", salida, exp_s);
        check("model_tick", tick, m_tick);
    endtask

    initial begin
        logic [NCH-1:0] e_t;
        logic [NCH-1:0] e_s;
        logic           b;

        reset_n     = 1'b0;
        habilitar   = 3'b111;
        sincronizar = 1'b0;
        wr_en       = 1'b0;
        wr_canal    = '0;
        wr_dato     = '0;
        #2;

        // Reset held for 3 edges with all channels enabled.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_salida", salida, 3'b000);
            check("rst_tick", tick, 3'b000);
        end

        // Default divisor 3: tick after every 4th running edge, salida period 8.
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            e_t = (k % 4 == 0) ? 3'b111 : 3'b000;
            e_s = (((k / 4) % 2) != 0) ? 3'b111 : 3'b000;
            check("def_tick", tick, e_t);
            check("def_salida", salida, e_s);
        end

        // Program ch0=0, ch1=1, ch2=4 while disabled, then enable all.
        habilitar = 3'b000;
        wr_en = 1'b1; wr_canal = 2'd0; wr_dato = 8'd0; step();
        wr_canal = 2'd1; wr_dato = 8'd1; step();
        wr_canal = 2'd2; wr_dato = 8'd4; step();
        wr_en = 1'b0; step();
        habilitar = 3'b111;
        for (int k = 1; k <= 20; k++) begin
            step();
            e_t[0] = 1'b1;           e_s[0] = (k % 2) != 0;
            e_t[1] = (k % 2 == 0);   e_s[1] = ((k / 2) % 2) != 0;
            e_t[2] = (k % 5 == 0);   e_s[2] = ((k / 5) % 2) != 0;
            check("div_tick", tick, e_t);
            check("div_salida", salida, e_s);
        end

        // Shadow load: ch2 D=4, write D=1 at running edge 2 -> wraps at 5, 7, 9, ...
        habilitar = 3'b000; step();
        habilitar = 3'b111;
        wr_canal = 2'd2; wr_dato = 8'd1;
        for (int k = 1; k <= 12; k++) begin
            wr_en = (k == 2);
            step();
            b = (k == 5) || (k > 5 && (k - 5) % 2 == 0);
            check("shadow_mid", {2'b00, tick[2]}, {2'b00, b});
        end
        wr_en = 1'b0;

        // Shadow load landing exactly on wrap edge 5 -> wraps at 5, 10, 12, ...
        habilitar = 3'b000;
        wr_en = 1'b1; wr_canal = 2'd2; wr_dato = 8'd4; step();
        wr_en = 1'b0; step();
        habilitar = 3'b111;
        wr_dato = 8'd1;
        for (int k = 1; k <= 16; k++) begin
            wr_en = (k == 5);
            step();
            b = (k == 5) || (k >= 10 && (k - 10) % 2 == 0);
            check("shadow_wrap", {2'b00, tick[2]}, {2'b00, b});
        end
        wr_en = 1'b0;

        // Enable: ch1 D=3, ch2 D=4; drop habilitar[1] mid-period for 3 cycles.
        habilitar = 3'b000;
        wr_en = 1'b1; wr_canal = 2'd1; wr_dato = 8'd3; step();
        wr_canal = 2'd2; wr_dato = 8'd4; step();
        wr_en = 1'b0; step();
        habilitar = 3'b111;
        for (int k = 1; k <= 6; k++) step();
        habilitar = 3'b101;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("dis_ch1", {salida[1], tick[1], 1'b0}, 3'b000);
            check("dis_ch0_tick", {2'b00, tick[0]}, 3'b001);
        end
        habilitar = 3'b111;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("reen_tick", {2'b00, tick[1]}, {2'b00, (k % 4 == 0)});
            check("reen_salida", {2'b00, salida[1]}, {2'b00, (((k / 4) % 2) != 0)});
        end

        // Sync pulse at arbitrary phases: all outputs clear, then common phase.
        for (int k = 1; k <= 3; k++) step();
        sincronizar = 1'b1; step();
        check("sync_salida", salida, 3'b000);
        check("sync_tick", tick, 3'b000);
        sincronizar = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            e_t[0] = 1'b1;           e_s[0] = (k % 2) != 0;
            e_t[1] = (k % 4 == 0);   e_s[1] = ((k / 4) % 2) != 0;
            e_t[2] = (k % 5 == 0);   e_s[2] = ((k / 5) % 2) != 0;
            check("sync_tick_run", tick, e_t);
            check("sync_salida_run", salida, e_s);
        end

        // Write to nonexistent channel 3 changes no divisor.
        wr_en = 1'b1; wr_canal = 2'd3; wr_dato = 8'd7; step();
        wr_en = 1'b0;
        habilitar = 3'b000; step(); step();
        habilitar = 3'b111;
        for (int k = 1; k <= 20; k++) begin
            step();
            e_t[0] = 1'b1;           e_s[0] = (k % 2) != 0;
            e_t[1] = (k % 4 == 0);   e_s[1] = ((k / 4) % 2) != 0;
            e_t[2] = (k % 5 == 0);   e_s[2] = ((k / 5) % 2) != 0;
            check("inval_tick", tick, e_t);
            check("inval_salida", salida, e_s);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 29) == 0) habilitar[i] = ~habilitar[i];
            end
            sincronizar = ($urandom_range(0, 59) == 0);
            wr_en       = ($urandom_range(0, 7) == 0);
            wr_canal    = 2'($urandom_range(0, 3));
            wr_dato     = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
